voice_mix_i2s_tx: RTL and testbench
===================================

# voice_mix_i2s_tx

Final output stage of the synthesizer. Sums the samples of all enveloped oscillator voices, applies a master attenuation shift and saturates the result. Serializes it as 16-bit I2S to the codec, with both channels carrying the same mono sample. Generates pbclk and pblrc from mclk; pblrc is the sample-rate clock consumed by the oscillator, envelope and filter stages.

## Interface
Parameters:
- NUM_VOICES, default 4: number of voice inputs; legal range 1..64.

Ports:
- mclk  in  1  master clock, 256x sample rate
- rst  in  1  asynchronous, active-high reset
- voice_samples  in  16 x NUM_VOICES  signed shortint sample per voice
- voice_valid  in  NUM_VOICES  per-voice enable; a voice with valid=0 contributes 0
- master_shift  in  4  arithmetic right shift applied to the sum (0..15)
- pbclk  out  1  I2S bit clock, mclk/4
- pblrc  out  1  I2S word clock, mclk/256; 0 = left, 1 = right
- pbdat  out  1  I2S serial data, MSB first
- frame_strobe  out  1  one-mclk pulse at the start of each frame
- clip  out  1  high for one full frame if the current frame's sample saturated

## Operation
- Free-running 8-bit counter cnt increments every mclk and wraps 255 -> 0.
  - Bit slot b = cnt[7:2], range 0..63.
- All outputs are registered, so they are glitch-free and aligned with cnt:
  - pbclk = cnt[1].
  - pblrc = cnt[7].
  - frame_strobe = (cnt == 0).
- Data framing (I2S, one bclk delay after the LRCLK edge, 32-bit slots):
  - Slots b=1..16 carry bits 15..0 of out_sample on the left channel.
  - Slots b=33..48 carry bits 15..0 of out_sample on the right channel.
  - All other slots carry 0.
- Mixer: a sequential accumulator, one voice per mclk.
  - At cnt == 128: acc <= 0.
  - At cnt == 129+i (i = 0..NUM_VOICES-1): acc <= acc + (voice_valid[i] ? sext(voice_samples[i]) : 0).
  - Accumulator width: 16 + clog2(NUM_VOICES) + 1 bits, signed. It never wraps.
- Finalize at cnt == 255:
  - shifted = acc >>> master_shift (arithmetic shift).
  - Saturate shifted to [-32768, 32767].
  - Load out_sample, which holds for the whole next frame.
  - clip_next = 1 if saturation occurred.
  - Left and right both serialize out_sample.
- Inputs are sampled only in the accumulate window. Changes outside it have no effect until the next frame.

## Timing
- Reset values:
  - cnt = 0, pbclk = 0, pblrc = 0, pbdat = 0.
  - frame_strobe = 0. It first asserts when cnt next reaches 0, i.e. 256 mclk after reset release.
  - out_sample = 0, acc = 0, clip = 0.
- pbdat edges:
  - pbdat changes only on mclk edges where cnt[1:0] becomes 0, which is the pbclk falling edge.
  - The codec samples pbdat on the pbclk rising edge, two mclk later.
- MSB placement: the left MSB occupies cnt 4..7 and the right MSB occupies cnt 132..135.
- Latency: voice i is sampled at cnt = 129+i of frame N. The result appears in frame N+1:
  - left MSB at cnt 4;
  - right MSB at cnt 132.
- clip timing:
  - clip updates at the same edge that loads out_sample (cnt 255 -> 0).
  - clip holds for 256 mclk.
- Reset mid-frame:
  - All state returns to its reset values immediately, asynchronously.
  - The frame in progress is discarded.
  - The first full frame after release transmits zeros.
- Accumulate window: it ends at cnt = 128 + NUM_VOICES, which is at most 192, well before finalize at 255.

## Test plan
- Reset release -> after 256 mclk, cnt == 0 and frame_strobe pulses once. Continuing from there:
  - pbclk period is 4 mclk;
  - pblrc period is 256 mclk with 50% duty;
  - pbdat = 0 for the first full frame.
- NUM_VOICES=4: voice0 = 0x1234 valid, others invalid, master_shift=0 -> the next frame serializes 0x1234 at b=1..16 and b=33..48, zeros elsewhere, and clip = 0.
- Four voices at 0x7000, all valid, shift=0 -> out_sample = 0x7FFF and clip = 1 for one frame. Then with shift=2 -> 0x7000, clip = 0.
- Four voices at -0x7000, shift=0 -> 0x8000 and clip = 1. Voices {+1000, -1000, 500, 0} -> 500 (0x01F4).
- A voice sample changed at cnt 200 of frame N -> no effect on frame N+1, which uses the value sampled at cnt 129. The change appears in frame N+2.
- Assert rst at cnt 40 of a frame carrying 0x5555 -> all outputs go to 0 immediately. After release, timing restarts from cnt 0 and the first frame is zeros.

Source files
------------

// File: rtl/voice_mix_i2s_tx_if.sv
// rtl/voice_mix_i2s_tx_if.sv - voice mixer inputs and I2S output bundle
interface voice_mix_i2s_tx_if #(
  parameter int NUM_VOICES = 4
);
  logic [NUM_VOICES-1:0][15:0] voice_samples;
  logic [NUM_VOICES-1:0]       voice_valid;
  logic [3:0]                  master_shift;
  logic                        pbclk;
  logic                        pblrc;
  logic                        pbdat;
  logic                        frame_strobe;
  logic                        clip;

  modport master (
    output voice_samples, voice_valid, master_shift,
    input  pbclk, pblrc, pbdat, frame_strobe, clip
  );

  modport slave (
    input  voice_samples, voice_valid, master_shift,
    output pbclk, pblrc, pbdat, frame_strobe, clip
  );
endinterface

// File: rtl/voice_mix_i2s_tx.sv
// rtl/voice_mix_i2s_tx.sv - voice mixer with attenuation, saturation and 16-bit I2S output
module voice_mix_i2s_tx #(
  parameter int NUM_VOICES = 4
) (
  input logic              mclk,
  input logic              rst,
  voice_mix_i2s_tx_if.slave bus
);
  localparam int AW = 16 + $clog2(NUM_VOICES) + 1;

  logic [7:0]           cnt;
  logic [7:0]           cnt_next;
  logic [5:0]           slot;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] addend;
  logic signed [AW-1:0] shifted;
  logic [15:0]          out_sample;
  logic [15:0]          sat_sample;
  logic                 sat;
  logic                 dat_next;

  assign cnt_next = cnt + 8'd1;
  assign slot     = cnt_next[7:2];

  // One voice per mclk in the accumulate window; zero outside it.
  always_comb begin
    addend = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (bus.voice_valid[i] && cnt == 8'(129 + i)) begin
        addend = {{(AW-16){bus.voice_samples[i][15]}}, bus.voice_samples[i]};
      end
    end
  end

  always_comb begin
    shifted    = acc >>> bus.master_shift;
    sat        = ~((&shifted[AW-1:15]) | ~(|shifted[AW-1:15]));
    sat_sample = shifted[15:0];
    if (sat) begin
      sat_sample = shifted[AW-1] ? 16'h8000 : 16'h7fff;
    end
  end

  // Data for the slot that the next edge enters; slots 0 and 17..32 stay low.
  always_comb begin
    dat_next = 1'b0;
    if (slot >= 6'd1 && slot <= 6'd16) begin
      dat_next = out_sample[4'(6'd16 - slot)];
    end else if (slot >= 6'd33 && slot <= 6'd48) begin
      dat_next = out_sample[4'(6'd48 - slot)];
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      acc              <= '0;
      out_sample       <= '0;
      bus.pbclk        <= 1'b0;
      bus.pblrc        <= 1'b0;
      bus.pbdat        <= 1'b0;
      bus.frame_strobe <= 1'b0;
      bus.clip         <= 1'b0;
    end else begin
      cnt              <= cnt_next;
      bus.pbclk        <= cnt_next[1];
      bus.pblrc        <= cnt_next[7];
      bus.frame_strobe <= (cnt_next == 8'd0);
      bus.pbdat        <= dat_next;
      if (cnt == 8'd128) begin
        acc <= '0;
      end else begin
        acc <= acc + addend;
      end
      if (cnt == 8'd255) begin
        out_sample <= sat_sample;
        bus.clip   <= sat;
      end
    end
  end
endmodule

// File: tb/tb_voice_mix_i2s_tx.sv
// tb/tb_voice_mix_i2s_tx.sv - self-checking bench for voice_mix_i2s_tx against a frame-level model
module tb_voice_mix_i2s_tx;
  localparam int NV = 4;
  localparam int NF = 64;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  int   k;
  int   c;
  int   f;
  int   vec  = 0;
  int   errs = 0;

  logic [15:0] exp_s [NF];
  bit          exp_c [NF];
  logic [15:0] hist_l [NF];
  logic [15:0] hist_r [NF];
  bit          hist_clip [NF];
  logic [15:0] cap_l;
  logic [15:0] cap_r;

  logic [NV-1:0][15:0] st_s;
  logic [NV-1:0]       st_v;
  logic [3:0]          st_sh;

  voice_mix_i2s_tx_if #(.NUM_VOICES(NV)) bus ();

  voice_mix_i2s_tx #(.NUM_VOICES(NV)) dut (
    .mclk(mclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 mclk = ~mclk;

  // Edges since reset release; equals the counter value modulo 256.
  always @(posedge mclk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, expv);
    end
  endtask

  function automatic void model(input logic [NV-1:0][15:0] s, input logic [NV-1:0] v,
                                input logic [3:0] sh, output logic [15:0] o, output bit cl);
    int sum;
    int sv;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (v[i]) sum += int'($signed(s[i]));
    end
    sv = sum >>> sh;
    cl = 1'b0;
    if (sv > 32767) begin
      sv = 32767;
      cl = 1'b1;
    end else if (sv < -32768) begin
      sv = -32768;
      cl = 1'b1;
    end
    o = 16'(sv);
  endfunction

  function automatic logic exp_bit(input logic [15:0] w, input int cc);
    int pos;
    pos = cc % 128 - 4;
    if (pos < 0 || pos >= 64) return 1'b0;
    return w[15 - pos / 4];
  endfunction

  task automatic step();
    @(negedge mclk);
    c = k % 256;
    f = k / 256;
    chk("pbclk", bus.pbclk, (k % 4) >= 2);
    chk("pblrc", bus.pblrc, c >= 128);
    chk("frame_strobe", bus.frame_strobe, (k > 0) && (c == 0));
    chk("clip", bus.clip, exp_c[f]);
    chk("pbdat", bus.pbdat, exp_bit(exp_s[f], c));
    if (c % 4 == 2) begin
      if (c >= 4 && c < 68)    cap_l = {cap_l[14:0], bus.pbdat};
      if (c >= 132 && c < 196) cap_r = {cap_r[14:0], bus.pbdat};
    end
    if (c == 128) hist_clip[f] = bus.clip;
    if (c == 255) begin
      hist_l[f] = cap_l;
      hist_r[f] = cap_r;
    end
  endtask

  task automatic run_frame(input bit disturb, input logic [15:0] dval);
    logic [15:0] o;
    bit          cl;
    do step(); while (c != 60);
    bus.voice_samples = st_s;
    bus.voice_valid   = st_v;
    bus.master_shift  = st_sh;
    model(st_s, st_v, st_sh, o, cl);
    exp_s[f+1] = o;
    exp_c[f+1] = cl;
    if (disturb) begin
      do step(); while (c != 200);
      bus.voice_samples[0] = dval;
    end
    do step(); while (c != 255);
  endtask

  task automatic set_all(input logic [15:0] val, input logic [3:0] sh);
    for (int i = 0; i < NV; i++) st_s[i] = val;
    st_v  = '1;
    st_sh = sh;
  endtask

  task automatic random_stim();
    for (int i = 0; i < NV; i++) begin
      st_s[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
    end
    st_v  = 4'($urandom);
    st_sh = 4'($urandom_range(0, 3));
  endtask

  initial begin
    logic [15:0] o;
    bit          cl;
    for (int i = 0; i < NF; i++) begin
      exp_s[i] = '0;
      exp_c[i] = 1'b0;
    end
    cap_l = '0;
    cap_r = '0;
    bus.voice_samples = '0;
    bus.voice_valid   = '0;
    bus.master_shift  = '0;
    st_s = '0; st_v = '0; st_sh = '0;

    repeat (3) @(negedge mclk);
    chk("reset_pbdat", bus.pbdat, 1'b0);
    chk("reset_pbclk", bus.pbclk, 1'b0);
    chk("reset_pblrc", bus.pblrc, 1'b0);
    chk("reset_strobe", bus.frame_strobe, 1'b0);
    chk("reset_clip", bus.clip, 1'b0);

    model({16'd0, 16'd0, 16'd0, 16'h0100}, 4'b0001, 4'd1, o, cl);
    chk("model_pin_shift", o, 16'h0080);
    rst = 1'b0;

    st_s = '0; st_s[0] = 16'h1234; st_v = 4'b0001; st_sh = 4'd0;
    run_frame(1'b0, 16'h0);
    set_all(16'h7000, 4'd0);  run_frame(1'b0, 16'h0);
    set_all(16'h7000, 4'd2);  run_frame(1'b0, 16'h0);
    set_all(16'h9000, 4'd0);  run_frame(1'b0, 16'h0);
    st_s = {16'd0, 16'd500, 16'hFC18, 16'd1000}; st_v = '1; st_sh = 4'd0;
    run_frame(1'b0, 16'h0);
    st_s = '0; st_s[0] = 16'h0100; st_v = 4'b0001;
    run_frame(1'b1, 16'h0200);
    st_s[0] = 16'h0200;
    run_frame(1'b0, 16'h0);
    for (int n = 0; n < 14; n++) begin
      random_stim();
      run_frame(1'b0, 16'h0);
    end
    step();

    chk("frame0_left",  hist_l[0], 16'h0000);
    chk("frame1_left",  hist_l[1], 16'h1234);
    chk("frame1_right", hist_r[1], 16'h1234);
    chk("frame1_clip",  hist_clip[1], 1'b0);
    chk("frame2_left",  hist_l[2], 16'h7FFF);
    chk("frame2_clip",  hist_clip[2], 1'b1);
    chk("frame3_left",  hist_l[3], 16'h7000);
    chk("frame3_clip",  hist_clip[3], 1'b0);
    chk("frame4_right", hist_r[4], 16'h8000);
    chk("frame4_clip",  hist_clip[4], 1'b1);
    chk("frame5_left",  hist_l[5], 16'h01F4);
    chk("frame6_left",  hist_l[6], 16'h0100);
    chk("frame7_left",  hist_l[7], 16'h0200);

    st_s = '0; st_s[0] = 16'h5555; st_v = 4'b0001; st_sh = 4'd0;
    run_frame(1'b0, 16'h0);
    do step(); while (c != 40);
    chk("pre_reset_pbdat", bus.pbdat, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < NF; i++) begin
      exp_s[i] = '0;
      exp_c[i] = 1'b0;
    end
    #1;
    chk("midreset_pbdat", bus.pbdat, 1'b0);
    chk("midreset_pbclk", bus.pbclk, 1'b0);
    chk("midreset_pblrc", bus.pblrc, 1'b0);
    chk("midreset_strobe", bus.frame_strobe, 1'b0);
    chk("midreset_clip", bus.clip, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      random_stim();
      run_frame(1'b0, 16'h0);
    end
    step();
    chk("post_reset_frame0", hist_l[0], 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
